// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame sequencer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int MIN_PRESCALE  = 8;
  localparam int SAMPLE_OFFSET = 2;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit counter; latches the effective
// prescale at frame start and reports wrap/compare flags to the sequencer.
module uart_rx_edge_bit_counter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int IDX_W      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  run_i,
  input  logic                  bit_clr_i,
  input  logic                  bit_inc_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_d_o,
  output logic [PRESCALE_W-1:0] mid_d_o,
  output logic [IDX_W-1:0]      bit_d_o,
  output logic                  edge_last_o,
  output logic                  edge_res_o,
  output logic                  bit_last_o
);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] per_q, per_d, per_in_s, mid_s;
  logic [IDX_W-1:0]      bit_q, bit_d;

  // Effective prescale: even, never below the minimum oversampling ratio.
  always_comb begin
    per_in_s = prescale_i & ~PRESCALE_W'(1);
    if (per_in_s < PRESCALE_W'(MIN_PRESCALE)) begin
      per_in_s = PRESCALE_W'(MIN_PRESCALE);
    end else begin
      per_in_s = per_in_s;
    end
    per_d       = load_i ? per_in_s : per_q;
    mid_s       = per_q >> 1;
    edge_last_o = (edge_q == per_q - PRESCALE_W'(1));
    edge_res_o  = (edge_q == mid_s + PRESCALE_W'(SAMPLE_OFFSET));
    bit_last_o  = (bit_q == IDX_W'(DATA_WIDTH - 1));
    if (!run_i || load_i || edge_last_o) begin
      edge_d = '0;
    end else begin
      edge_d = edge_q + PRESCALE_W'(1);
    end
    if (bit_clr_i) begin
      bit_d = '0;
    end else if (bit_inc_i) begin
      bit_d = bit_q + IDX_W'(1);
    end else begin
      bit_d = bit_q;
    end
  end

  assign edge_d_o = edge_d;
  assign mid_d_o  = per_d >> 1;
  assign bit_d_o  = bit_d;

  // Counter and latched-prescale state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_q <= '0;
      bit_q  <= '0;
      per_q  <= PRESCALE_W'(MIN_PRESCALE);
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
      per_q  <= per_d;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start detection, per-bit strobes to the
// sampler/deserializer/checkers, and one result pulse per frame.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RX_IN,
  input  logic [PRESCALE_W-1:0]         PRESCALE,
  input  logic                          PAR_EN,
  input  logic                          STRT_GLITCH,
  input  logic                          PAR_ERR,
  input  logic                          STP_ERR,
  output logic                          SAMPLE_EN,
  output logic                          STRT_CHK_EN,
  output logic                          DESER_EN,
  output logic [$clog2(DATA_WIDTH)-1:0] BIT_IDX,
  output logic                          PAR_CHK_EN,
  output logic                          STP_CHK_EN,
  output logic                          ERR_RST,
  output logic                          BUSY,
  output logic                          DATA_VALID,
  output logic                          FRAME_ERR
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic                  par_en_q, res_win_q, res_win_d;
  logic                  sample_en_q, strt_chk_en_q, deser_en_q, par_chk_en_q;
  logic                  stp_chk_en_q, err_rst_q, busy_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic                  load_s, bit_clr_s, bit_inc_s, in_frame_s, win_s, chk_s, err_s;
  logic [PRESCALE_W-1:0] edge_d_s, mid_d_s;
  logic [IDX_W-1:0]      bit_d_s;
  logic                  edge_last_s, edge_res_s, bit_last_s;

  uart_rx_edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W),
    .IDX_W      (IDX_W)
  ) u_cnt (
    .clk_i       (CLK),
    .rst_i       (RST),
    .load_i      (load_s),
    .run_i       (in_frame_s),
    .bit_clr_i   (bit_clr_s),
    .bit_inc_i   (bit_inc_s),
    .prescale_i  (PRESCALE),
    .edge_d_o    (edge_d_s),
    .mid_d_o     (mid_d_s),
    .bit_d_o     (bit_d_s),
    .edge_last_o (edge_last_s),
    .edge_res_o  (edge_res_s),
    .bit_last_o  (bit_last_s)
  );

  // Next-state logic; STOP exits one cycle early so the result cycle is
  // already IDLE and can catch an immediately following start bit.
  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    bit_clr_s = 1'b0;
    bit_inc_s = 1'b0;
    res_win_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d = START;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (edge_last_s) begin
          state_d   = STRT_GLITCH ? IDLE : DATA;
          bit_clr_s = ~STRT_GLITCH;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (edge_last_s && bit_last_s) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          bit_inc_s = edge_last_s;
        end
      end
      PARITY: begin
        state_d = edge_last_s ? STOP : PARITY;
      end
      STOP: begin
        if (edge_res_s) begin
          state_d   = IDLE;
          res_win_d = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
    in_frame_s = (state_d != IDLE);
    win_s      = (edge_d_s >= mid_d_s - PRESCALE_W'(1)) && (edge_d_s <= mid_d_s + PRESCALE_W'(1));
    chk_s      = in_frame_s && (edge_d_s == mid_d_s + PRESCALE_W'(SAMPLE_OFFSET));
    err_s      = STP_ERR | (par_en_q & PAR_ERR);
  end

  // State register and strobes decoded from the upcoming state/edge count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      par_en_q      <= 1'b0;
      sample_en_q   <= 1'b0;
      strt_chk_en_q <= 1'b0;
      deser_en_q    <= 1'b0;
      bit_idx_q     <= '0;
      par_chk_en_q  <= 1'b0;
      stp_chk_en_q  <= 1'b0;
      err_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      res_win_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      par_en_q      <= load_s ? PAR_EN : par_en_q;
      sample_en_q   <= in_frame_s && win_s;
      strt_chk_en_q <= chk_s && (state_d == START);
      deser_en_q    <= chk_s && (state_d == DATA);
      bit_idx_q     <= (chk_s && (state_d == DATA)) ? bit_d_s : '0;
      par_chk_en_q  <= chk_s && (state_d == PARITY);
      stp_chk_en_q  <= chk_s && (state_d == STOP);
      err_rst_q     <= ~load_s;
      busy_q        <= in_frame_s;
      res_win_q     <= res_win_d;
    end
  end

  assign SAMPLE_EN   = sample_en_q;
  assign STRT_CHK_EN = strt_chk_en_q;
  assign DESER_EN    = deser_en_q;
  assign BIT_IDX     = bit_idx_q;
  assign PAR_CHK_EN  = par_chk_en_q;
  assign STP_CHK_EN  = stp_chk_en_q;
  assign ERR_RST     = err_rst_q;
  assign BUSY        = busy_q;
  // Checker flags are registered, so the result qualifies them directly.
  assign DATA_VALID  = res_win_q & ~err_s;
  assign FRAME_ERR   = res_win_q & err_s;

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Frame sequencer for the UART receive path. It detects the start bit and counts oversampling edges and bit positions. It issues one-cycle enable strobes to the sampler, deserializer, start/parity/stop checkers, and the active-low error-clear input of the parity checker. It combines the checkers' registered error flags into a single DATA_VALID or FRAME_ERR pulse per frame.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of PRESCALE input and edge counter

Ports:
CLK  in  1  system clock (RX clock domain)
RST  in  1  synchronous, active-high reset
RX_IN  in  1  serial line, idle high
PRESCALE  in  PRESCALE_W  oversampling ratio (8/16/32 nominal)
PAR_EN  in  1  1 = frame carries parity bit
STRT_GLITCH  in  1  start checker result, registered, valid 1 cycle after STRT_CHK_EN
PAR_ERR  in  1  parity checker result, registered, valid 1 cycle after PAR_CHK_EN
STP_ERR  in  1  stop checker result, registered, valid 1 cycle after STP_CHK_EN
SAMPLE_EN  out  1  sampler majority-vote window enable
STRT_CHK_EN  out  1  start-check strobe
DESER_EN  out  1  deserializer shift strobe
BIT_IDX  out  $clog2(DATA_WIDTH)  data bit index accompanying DESER_EN
PAR_CHK_EN  out  1  parity-check strobe
STP_CHK_EN  out  1  stop-check strobe
ERR_RST  out  1  active-low error clear to checkers
BUSY  out  1  frame in progress
DATA_VALID  out  1  one-cycle pulse, good frame
FRAME_ERR  out  1  one-cycle pulse, bad frame (parity or stop)

Behaviour:
- Reset, RST=1 at a CLK edge:
  - state=IDLE, counters=0.
  - All outputs 0, except ERR_RST=1 (inactive).
  - Reset mid-frame abandons the frame; no DATA_VALID or FRAME_ERR is emitted.
- Effective prescale P:
  - PRESCALE with LSB forced to 0.
  - Values below 8 are clamped to 8.
  - Mid-point M = P/2.
- edge_cnt counts 0..P-1 within each bit and wraps at P-1. bit_cnt counts data bits.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If RX_IN=0: next state START, edge_cnt=0, ERR_RST=0 for that one cycle.
  - Otherwise stay in IDLE.
  - BUSY=0 in IDLE only.
- In every non-IDLE state:
  - SAMPLE_EN=1 while edge_cnt is in {M-1, M, M+1}.
  - The state's check strobe pulses when edge_cnt=M+2.
- START:
  - STRT_CHK_EN at M+2.
  - At edge_cnt=P-1: if STRT_GLITCH=1, go to IDLE (no other strobes); else go to DATA with bit_cnt=0.
- DATA:
  - DESER_EN with BIT_IDX=bit_cnt at M+2. LSB is received first.
  - At P-1: if bit_cnt=DATA_WIDTH-1, go to PARITY when PAR_EN=1, else STOP. Otherwise bit_cnt++.
- PARITY:
  - PAR_CHK_EN at M+2.
  - At P-1: go to STOP.
- STOP:
  - STP_CHK_EN at M+2.
  - At edge_cnt=M+3: if PAR_ERR|STP_ERR, FRAME_ERR=1; else DATA_VALID=1 (one cycle). Then go to IDLE.
  - Leaving early gives half-bit margin for back-to-back frames.
  - PAR_ERR is ignored when PAR_EN=0.
- PAR_EN and PRESCALE are sampled at the IDLE→START transition and held for the frame.
- DATA_VALID and FRAME_ERR are mutually exclusive.
- All strobes are registered outputs and are never high outside their state.
- Latency, counted from the first START cycle:
  - With PAR_EN=1, the result pulse occurs at cycle (DATA_WIDTH+2)·P + M + 3.
  - With PAR_EN=0, it occurs at cycle (DATA_WIDTH+1)·P + M + 3.

Decomposition:
- Shared package uart_pkg:
  - State enum encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
  - MIN_PRESCALE=8.
  - SAMPLE_OFFSET=2, the check strobe offset from M.
- One natural sub-module, uart_rx_edge_bit_counter: holds edge_cnt and bit_cnt, computes P/M, and generates wrap flags.
- The FSM and strobe decode stay in uart_rx_fsm.

Test Plan:
- PRESCALE=8, PAR_EN=1, byte 0xA5 with correct even parity, checkers modelled clean -> exactly 8 DESER_EN pulses with BIT_IDX 0..7; ERR_RST low for 1 cycle; DATA_VALID high for one cycle at cycle 87 after START entry.
- Same frame with PAR_ERR=1 returned after PAR_CHK_EN -> FRAME_ERR pulse at cycle 87; DATA_VALID stays 0.
- RX_IN low for 2 cycles then high, STRT_GLITCH=1 -> return to IDLE at cycle 7; no DESER_EN; no result pulse; BUSY drops.
- PAR_EN=0, PRESCALE=16, byte 0x3C -> no PAR_CHK_EN; DATA_VALID at cycle 9·16+11 = 155.
- Two back-to-back frames with the second start bit immediately after the stop bit, PRESCALE=8 -> two DATA_VALID pulses 88 cycles apart. Separately, RST at cycle 40 of a frame -> all outputs 0 and IDLE next cycle; no result pulse.
- PRESCALE=5 -> behaves as P=8; PRESCALE=33 -> behaves as P=32, with SAMPLE_EN at edges 15–17.
